cc_frame_serializer: RTL and testbench
======================================

CC_FRAME_SERIALIZER -- requirements
Module: cc_frame_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clocks per serial bit (minimum 4).
REQ-002 SHALL have parameter FRAME_BYTES, default 2048, meaning payload bytes read from the frame RAM per frame (minimum 1).
REQ-003 SHALL have parameter ADDR_W, default 12, meaning the RAM byte-address width.
REQ-004 SHALL have parameter SYNC_BYTE, default 8'hFF, meaning the header byte value, sent twice.
REQ-005 SHALL have parameter RD_LAT, default 2, meaning clocks from rdaddress change to valid data.
REQ-006 SHALL have ports (one per line, in this order):
  - clock  input  1  sole clock.
  - reset  input  1  synchronous, active-high.
  - RDY  input  1  frame-ready request; the rising edge is used.
  - rdaddress  output  ADDR_W  byte address into the frame RAM.
  - data  input  8  RAM read data, valid RD_LAT clocks after rdaddress.
  - tx  output  1  UART 8N1 line, idle high.
  - busy  output  1  high from frame accept through the last stop bit.
  - done  output  1  1-clock pulse at frame completion.
  - overrun  output  1  1-clock pulse when an RDY edge arrives while busy.

Function
REQ-007 SHALL register RDY once and detect its rising edge; a RDY held high SHALL start exactly one frame.
REQ-008 SHALL accept an RDY edge only in IDLE; busy SHALL rise on the clock after the accepted edge.
REQ-009 SHALL, on an RDY edge while busy, pulse overrun for 1 clock and leave the current frame untouched; the request SHALL NOT be queued.
REQ-010 SHALL transmit each frame as: SYNC_BYTE, SYNC_BYTE, payload bytes at addresses 0..FRAME_BYTES-1 in ascending order, then a checksum byte.
REQ-011 SHALL compute the checksum as the 8-bit sum mod 256 of payload bytes only, cleared at frame accept.
REQ-012 SHALL send each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); every bit SHALL last exactly CLK_DIV clocks.
REQ-013 SHALL send bytes back-to-back with no idle clocks, so that a frame lasts exactly (FRAME_BYTES+3)*10*CLK_DIV clocks from the first start bit.
REQ-014 SHALL prefetch the next payload byte:
  - rdaddress SHALL advance at the start bit of the current byte.
  - data SHALL be sampled RD_LAT clocks later into a holding register.
REQ-015 SHALL drive the first start bit on the clock after busy rises.
REQ-016 SHALL hold rdaddress at 0 while idle; address 0 SHALL be presented no later than the first sync byte.
REQ-017 SHALL implement the FSM states IDLE -> SYNC (2 bytes) -> PAYLOAD (FRAME_BYTES bytes) -> CSUM (1 byte) -> DONE -> IDLE.
REQ-018 SHALL spend exactly 1 clock in DONE; done SHALL pulse and busy SHALL fall there.
REQ-019 SHALL keep tx high in IDLE and DONE.
REQ-020 SHALL compare the payload counter against FRAME_BYTES-1 before the ADDR_W-bit address wraps; if FRAME_BYTES = 2^ADDR_W, the address SHALL wrap to 0 only after the last byte.
REQ-021 SHALL count an RDY edge coinciding with the DONE clock as overrun (not accepted); an edge on the clock after DONE SHALL be accepted.
REQ-022 SHALL recover from unsafe FSM encodings to IDLE with tx high.

Reset
REQ-023 SHALL, when reset is sampled high, set on the next clock:
  - tx=1, busy=0, done=0, overrun=0, rdaddress=0.
  - checksum=0, all counters=0, RDY edge register=0.
  - state=IDLE.
REQ-024 SHALL, on reset mid-frame, abandon the frame with no done pulse; tx SHALL be high on the next clock.
REQ-025 SHALL ignore RDY during reset and SHALL NOT treat an RDY already high at reset release as an edge.

Structure
REQ-026 SHALL place the FSM state encoding, SYNC_LEN=2 and BITS_PER_BYTE=10 in the shared cc package; parameter defaults stay local.
REQ-027 SHALL use one sub-module, cc_uart_byte_tx: load/byte inputs, tx/ready outputs, with CLK_DIV as a parameter.

Verification
REQ-028 SHALL cover a basic frame:
  - Setup: CLK_DIV=4, FRAME_BYTES=4, RAM = 01,02,03,FA, RDY pulse.
  - Expect: tx bytes FF FF 01 02 03 FA 00.
  - Expect: busy high for 1+280 clocks, then done for 1 clock.
REQ-029 SHALL cover checksum wrap:
  - Setup: RAM = 80,80,FF,01.
  - Expect: checksum byte 00.
  - Expect: each bit exactly 4 clocks; no idle gap between bytes.
REQ-030 SHALL cover overrun:
  - Stimulus: RDY pulses at clocks 50 and 100 of a frame.
  - Expect: two 1-clock overrun pulses, one frame sent, no second frame.
REQ-031 SHALL cover reset mid-frame:
  - Stimulus: reset during payload byte 2.
  - Expect: next clock tx=1, busy=0, rdaddress=0, no done.
  - Expect: a new RDY yields a full correct frame.
REQ-032 SHALL cover RDY held high:
  - Stimulus: RDY high for 500 clocks.
  - Expect: exactly one frame.
  - Expect: an RDY rising edge on the clock after DONE starts a second frame.
REQ-033 SHALL cover RAM latency:
  - Setup: RD_LAT=1 and RD_LAT=2, with RAM holding an address-indexed pattern.
  - Expect: every payload byte matches its address; FRAME_BYTES=2^ADDR_W ends at address wrap.

Source files
------------

// File: rtl/cc_pkg.sv
// cc_pkg: FSM encoding and framing constants shared by the
// cc frame serializer and its UART byte transmitter.
package cc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DONE
  } state_t;

  localparam int SYNC_LEN = 2;
  localparam int BITS_PER_BYTE = 10;

endpackage

// File: rtl/cc_uart_byte_tx.sv
// cc_uart_byte_tx: 8N1 byte transmitter, CLK_DIV clocks per bit.
// ready rises in the last stop-bit clock so bytes chain gap-free.
module cc_uart_byte_tx
  import cc_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       ready
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic             active;
  logic [DIV_W-1:0] div;
  logic [3:0]       bit_idx;
  logic [8:0]       sh;
  logic             bit_end;
  logic             last_bit;

  assign bit_end  = (div == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_idx == 4'(BITS_PER_BYTE - 1));
  assign ready    = !active || (bit_end && last_bit);

  always_ff @(posedge clock) begin
    if (reset) begin
      active  <= 1'b0;
      div     <= '0;
      bit_idx <= '0;
      sh      <= '1;
      tx      <= 1'b1;
    end else if (load && ready) begin
      active  <= 1'b1;
      div     <= '0;
      bit_idx <= '0;
      sh      <= {1'b1, tx_byte};
      tx      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        div <= '0;
        if (last_bit) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx      <= sh[0];
          sh      <= {1'b1, sh[8:1]};
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc_frame_serializer.sv
// cc_frame_serializer: sends SYNC SYNC <payload> <sum8> from a
// latency-RD_LAT frame RAM over UART on each accepted RDY edge.
module cc_frame_serializer
  import cc_pkg::*;
#(
  parameter int         CLK_DIV     = 16,
  parameter int         FRAME_BYTES = 2048,
  parameter int         ADDR_W      = 12,
  parameter logic [7:0] SYNC_BYTE   = 8'hFF,
  parameter int         RD_LAT      = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RDY,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [7:0]        data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = $clog2(FRAME_BYTES) + 1;
  localparam int LAT_W = $clog2(RD_LAT + 2);

  state_t           state, state_nx;
  logic             rdy_q, armed, rise;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       hold, csum, tx_byte;
  logic [LAT_W-1:0] lat;
  logic             pend, sent;
  logic             load, ready, utx;
  logic             accept, bad, last_pay;

  cc_uart_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clock  (clock),
    .reset  (reset | bad),
    .load   (load),
    .tx_byte(tx_byte),
    .tx     (utx),
    .ready  (ready)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    rise     = RDY & ~rdy_q & armed & ~reset;
    last_pay = (cnt == CNT_W'(FRAME_BYTES - 1));
    state_nx = state;
    load     = 1'b0;
    tx_byte  = SYNC_BYTE;
    accept   = 1'b0;
    bad      = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    overrun  = 1'b0;
    tx       = 1'b1;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          accept   = 1'b1;
          state_nx = ST_SYNC;
        end
      end
      ST_SYNC: begin
        busy    = 1'b1;
        tx      = utx;
        overrun = rise;
        load    = ready;
        if (ready && cnt == CNT_W'(SYNC_LEN - 1))
          state_nx = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        busy    = 1'b1;
        tx      = utx;
        overrun = rise;
        tx_byte = hold;
        load    = ready;
        if (ready && last_pay) state_nx = ST_CSUM;
      end
      ST_CSUM: begin
        busy    = 1'b1;
        tx      = utx;
        overrun = rise;
        tx_byte = csum;
        load    = ready & ~sent;
        if (ready && sent) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        overrun  = rise;
        state_nx = ST_IDLE;
      end
      default: begin
        bad      = 1'b1;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Each load starts the fetch of the byte after the one on the line.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      armed     <= 1'b0;
      cnt       <= '0;
      rdaddress <= '0;
      hold      <= '0;
      csum      <= '0;
      lat       <= '0;
      pend      <= 1'b0;
      sent      <= 1'b0;
    end else begin
      rdy_q <= RDY;
      if (!RDY) armed <= 1'b1;
      if (pend) begin
        if (lat == '0) begin
          hold <= data;
          pend <= 1'b0;
        end else begin
          lat <= lat - 1'b1;
        end
      end
      if (accept) begin
        cnt       <= '0;
        csum      <= '0;
        sent      <= 1'b0;
        rdaddress <= '0;
        pend      <= 1'b1;
        lat       <= LAT_W'(RD_LAT);
      end
      if (load) begin
        case (state)
          ST_SYNC: begin
            if (cnt == CNT_W'(SYNC_LEN - 1)) cnt <= '0;
            else cnt <= cnt + 1'b1;
          end
          ST_PAYLOAD: begin
            csum <= csum + hold;
            cnt  <= cnt + 1'b1;
            if (last_pay) begin
              rdaddress <= '0;
            end else begin
              rdaddress <= rdaddress + 1'b1;
              pend      <= 1'b1;
              lat       <= LAT_W'(RD_LAT);
            end
          end
          ST_CSUM: sent <= 1'b1;
          default: ;
        endcase
      end
      if (state == ST_DONE || bad) rdaddress <= '0;
    end
  end

endmodule

// File: tb/tb_cc_frame_serializer.sv
// tb_cc_frame_serializer: directed checks of framing, checksum,
// overrun, reset and RAM latency on two small instances.
module tb_cc_frame_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rdy = 1'b0;
  logic       rdy2 = 1'b0;
  logic [1:0] rdaddress, rdaddress2;
  logic [7:0] data, data2;
  logic       tx, busy, done, overrun;
  logic       tx2, busy2, done2, overrun2;

  logic [7:0] mem [4];
  logic [7:0] p1, p2, q1;

  logic       tx_log   [700];
  logic       busy_log [700];
  logic       done_log [700];
  logic       ovr_log  [700];
  logic [1:0] addr_log [700];
  logic [7:0] got [7];
  logic       framing;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    p1 <= mem[rdaddress];
    p2 <= p1;
    q1 <= mem[rdaddress2];
  end
  assign data  = p2;
  assign data2 = q1;

  cc_frame_serializer #(
    .CLK_DIV(4), .FRAME_BYTES(4), .ADDR_W(2),
    .SYNC_BYTE(8'hFF), .RD_LAT(2)
  ) dut (
    .clock(clock), .reset(reset), .RDY(rdy),
    .rdaddress(rdaddress), .data(data), .tx(tx),
    .busy(busy), .done(done), .overrun(overrun)
  );

  cc_frame_serializer #(
    .CLK_DIV(4), .FRAME_BYTES(4), .ADDR_W(2),
    .SYNC_BYTE(8'hFF), .RD_LAT(1)
  ) dut2 (
    .clock(clock), .reset(reset), .RDY(rdy2),
    .rdaddress(rdaddress2), .data(data2), .tx(tx2),
    .busy(busy2), .done(done2), .overrun(overrun2)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Log cycle i just before posedge i; RDY high within the windows.
  task automatic run(input int n, input bit sel, input int a,
                     input int b, input int c, input int w);
    for (int i = 0; i < n; i++) begin
      logic r;
      r = (i >= a && i < a + w) || (i >= b && i < b + w) ||
          (i >= c && i < c + w);
      if (sel) rdy2 = r;
      else rdy = r;
      #1;
      tx_log[i]   = sel ? tx2 : tx;
      busy_log[i] = sel ? busy2 : busy;
      done_log[i] = sel ? done2 : done;
      ovr_log[i]  = sel ? overrun2 : overrun;
      addr_log[i] = sel ? rdaddress2 : rdaddress;
      @(negedge clock);
    end
    rdy  = 1'b0;
    rdy2 = 1'b0;
  endtask

  function automatic int find_start(input int lim);
    for (int i = 0; i < lim; i++)
      if (tx_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int count_of(input int which, input int n);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (which == 0 && busy_log[i] === 1'b1) k++;
      if (which == 1 && done_log[i] === 1'b1) k++;
      if (which == 2 && ovr_log[i] === 1'b1) k++;
    end
    return k;
  endfunction

  task automatic decode(input int s);
    framing = 1'b1;
    for (int k = 0; k < 7; k++)
      for (int j = 0; j < 10; j++) begin
        logic v;
        v = tx_log[s + k * 40 + j * 4];
        for (int c = 1; c < 4; c++)
          if (tx_log[s + k * 40 + j * 4 + c] !== v) framing = 1'b0;
        if (j == 0 && v !== 1'b0) framing = 1'b0;
        if (j == 9 && v !== 1'b1) framing = 1'b0;
        if (j >= 1 && j <= 8) got[k][j-1] = v;
      end
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    idle(2);
    #1;
    checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
    else passed++;
    checks++;
    if (overrun !== 1'b0)
      $display("FAIL reset_overrun got %b want 0", overrun);
    else passed++;
    checks++;
    if (rdaddress !== 2'd0)
      $display("FAIL reset_addr got %0d want 0", rdaddress);
    else passed++;
    reset = 1'b0;
    run(30, 0, 0, -1000, -1000, 30);
    checks++;
    if (count_of(0, 30) !== 0)
      $display("FAIL rdy_high_at_release busy cycles %0d want 0",
               count_of(0, 30));
    else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] exp [7];
    int s;
    exp = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'hFA, 8'h00};
    mem = '{8'h01, 8'h02, 8'h03, 8'hFA};
    idle(3);
    run(300, 0, 0, -1000, -1000, 1);
    s = find_start(40);
    checks++;
    if (s !== 2) $display("FAIL basic_start got %0d want 2", s);
    else passed++;
    if (s < 0) s = 2;
    decode(s);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== exp[k])
        $display("FAIL basic_byte%0d got %h want %h", k, got[k], exp[k]);
      else passed++;
    end
    checks++;
    if (framing !== 1'b1) $display("FAIL basic_framing got 0 want 1");
    else passed++;
    checks++;
    if (count_of(0, 300) !== 281 || busy_log[1] !== 1'b1 ||
        busy_log[281] !== 1'b1)
      $display("FAIL basic_busy got %0d cycles want 281 from cycle 1",
               count_of(0, 300));
    else passed++;
    checks++;
    if (done_log[282] !== 1'b1 || count_of(1, 300) !== 1)
      $display("FAIL basic_done at282 %b count %0d want 1/1",
               done_log[282], count_of(1, 300));
    else passed++;
    checks++;
    if (tx_log[282] !== 1'b1 || busy_log[282] !== 1'b0)
      $display("FAIL basic_done_line tx %b busy %b want 1/0",
               tx_log[282], busy_log[282]);
    else passed++;
    checks++;
    if (addr_log[s+79] !== 2'd0 || addr_log[s+80] !== 2'd1)
      $display("FAIL basic_prefetch addr %0d,%0d want 0,1",
               addr_log[s+79], addr_log[s+80]);
    else passed++;
  endtask

  task automatic test_csum_wrap();
    logic [7:0] exp [7];
    exp = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'h01, 8'h00};
    mem = '{8'h80, 8'h80, 8'hFF, 8'h01};
    idle(3);
    run(300, 0, 0, -1000, -1000, 1);
    decode(2);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== exp[k])
        $display("FAIL wrap_byte%0d got %h want %h", k, got[k], exp[k]);
      else passed++;
    end
    checks++;
    if (framing !== 1'b1 || tx_log[1] !== 1'b1 || tx_log[282] !== 1'b1)
      $display("FAIL wrap_timing framing %b want 1", framing);
    else passed++;
  endtask

  task automatic test_overrun();
    mem = '{8'h01, 8'h02, 8'h03, 8'hFA};
    idle(3);
    run(330, 0, 0, 50, 100, 1);
    checks++;
    if (count_of(2, 330) !== 2 || ovr_log[50] !== 1'b1 ||
        ovr_log[100] !== 1'b1)
      $display("FAIL overrun_pulses got %0d want 2 at 50,100",
               count_of(2, 330));
    else passed++;
    checks++;
    if (count_of(0, 330) !== 281 || count_of(1, 330) !== 1)
      $display("FAIL overrun_one_frame busy %0d done %0d want 281/1",
               count_of(0, 330), count_of(1, 330));
    else passed++;
    decode(2);
    checks++;
    if (got[6] !== 8'h00 || framing !== 1'b1)
      $display("FAIL overrun_frame csum %h want 00", got[6]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [7];
    exp = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'hFA, 8'h00};
    mem = '{8'h01, 8'h02, 8'h03, 8'hFA};
    idle(3);
    run(140, 0, 0, -1000, -1000, 1);
    checks++;
    if (busy_log[139] !== 1'b1 || addr_log[139] !== 2'd2)
      $display("FAIL mid_state busy %b addr %0d want 1/2",
               busy_log[139], addr_log[139]);
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || rdaddress !== 2'd0 ||
        done !== 1'b0)
      $display("FAIL mid_reset tx %b busy %b addr %0d done %b want 1 0 0 0",
               tx, busy, rdaddress, done);
    else passed++;
    reset = 1'b0;
    idle(3);
    run(300, 0, 0, -1000, -1000, 1);
    decode(2);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== exp[k])
        $display("FAIL mid_byte%0d got %h want %h", k, got[k], exp[k]);
      else passed++;
    end
    checks++;
    if (done_log[282] !== 1'b1 || count_of(1, 300) !== 1)
      $display("FAIL mid_done got %b want 1", done_log[282]);
    else passed++;
  endtask

  task automatic test_rdy_held();
    idle(3);
    run(600, 0, 0, -1000, -1000, 500);
    checks++;
    if (count_of(0, 600) !== 281 || count_of(1, 600) !== 1 ||
        count_of(2, 600) !== 0)
      $display("FAIL held_one_frame busy %0d done %0d ovr %0d",
               count_of(0, 600), count_of(1, 600), count_of(2, 600));
    else passed++;
  endtask

  task automatic test_done_edge();
    idle(3);
    run(600, 0, 0, 282, -1000, 1);
    checks++;
    if (ovr_log[282] !== 1'b1 || count_of(0, 600) !== 281)
      $display("FAIL done_edge ovr %b busy %0d want 1/281",
               ovr_log[282], count_of(0, 600));
    else passed++;
    idle(3);
    run(600, 0, 0, 283, -1000, 1);
    checks++;
    if (busy_log[284] !== 1'b1 || count_of(0, 600) !== 562 ||
        count_of(1, 600) !== 2 || done_log[565] !== 1'b1)
      $display("FAIL after_done_edge busy %0d done %0d want 562/2",
               count_of(0, 600), count_of(1, 600));
    else passed++;
  endtask

  task automatic test_latency();
    logic [7:0] exp [7];
    exp = '{8'hFF, 8'hFF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h86};
    mem = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int sel = 0; sel < 2; sel++) begin
      idle(3);
      run(300, sel[0], 0, -1000, -1000, 1);
      decode(2);
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (got[k] !== exp[k])
          $display("FAIL lat%0d_byte%0d got %h want %h",
                   2 - sel, k, got[k], exp[k]);
        else passed++;
      end
      checks++;
      if (addr_log[162] !== 2'd3 || addr_log[202] !== 2'd0 ||
          addr_log[283] !== 2'd0)
        $display("FAIL lat%0d_wrap addr %0d,%0d want 3,0",
                 2 - sel, addr_log[162], addr_log[202]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_csum_wrap();
    test_overrun();
    test_reset_mid();
    test_rdy_held();
    test_done_edge();
    test_latency();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
